l0_ctrl: RTL and testbench

Sequencer for the L0 input buffer. It fetches a tile of `num_vec` activation vectors from the activation SRAM into L0, then drains them into the MAC array. Drain runs in one of two modes: broadcast (all rows popped per read) or cascade (one row per read, rotating row 0 → row-1). It tracks L0 occupancy, applies SRAM-side and array-side backpressure, and re-aligns L0's one-hot row pointer whenever cascade mode is entered.

---
 rtl/l0_ctrl.sv | 148 ++++++++++++++
 tb/tb_l0_ctrl.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l0_ctrl.sv
// l0_ctrl -- sequencer for the L0 input buffer.
//
// Fetches a tile of num_vec activation vectors from the activation SRAM into
// L0, then drains them into the MAC array, either in broadcast mode (every row
// popped per read) or cascade mode (one row per read, rotating 0 .. row-1).
// Tracks L0 occupancy with the in-flight write reserved at issue, so L0 never
// overflows. Entering cascade mode spends one ALIGN cycle with l0_cascade high
// and no traffic, which parks L0's one-hot row pointer on row 0.
//
// Ports
//   clk, reset     : single clock, asynchronous active-high reset
//   start          : tile start pulse, only honoured in IDLE
//   num_vec        : vectors in the tile (0..depth), captured at start
//   base_addr      : first SRAM address, captured at start
//   cascade_mode   : 1 = cascade drain, 0 = broadcast, captured at start
//   array_ready    : MAC array accepts an L0 read this cycle
//   l0_ready       : L0 has at least one row that is not full
//   sram_rd        : SRAM read strobe (combinational)
//   sram_addr      : SRAM read address (registered, base_addr + issued count)
//   l0_wr          : L0 write, sram_rd delayed by one cycle
//   l0_rd          : L0 read request (combinational)
//   l0_cascade     : L0 mode select, holds its value until the next start
//   busy           : controller not idle
//   done           : one-cycle tile-complete pulse
module l0_ctrl #(
  parameter int row    = 8,
  parameter int depth  = 64,
  parameter int cnt_w  = 7,
  parameter int addr_w = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [cnt_w-1:0]  num_vec,
  input  logic [addr_w-1:0] base_addr,
  input  logic              cascade_mode,
  input  logic              array_ready,
  input  logic              l0_ready,
  output logic              sram_rd,
  output logic [addr_w-1:0] sram_addr,
  output logic              l0_wr,
  output logic              l0_rd,
  output logic              l0_cascade,
  output logic              busy,
  output logic              done
);

  localparam int ph_w = (row > 1) ? $clog2(row) : 1;

  localparam logic [1:0] st_idle  = 2'd0;
  localparam logic [1:0] st_align = 2'd1;
  localparam logic [1:0] st_run   = 2'd2;
  localparam logic [1:0] st_done  = 2'd3;

  localparam logic [cnt_w:0]    depth_lim = (cnt_w + 1)'(depth);
  localparam logic [cnt_w-1:0]  cnt_one   = cnt_w'(1);
  localparam logic [addr_w-1:0] addr_one  = addr_w'(1);
  localparam logic [ph_w-1:0]   ph_one    = ph_w'(1);
  localparam logic [ph_w-1:0]   ph_last   = ph_w'(row - 1);

  logic [1:0]       state, state_n;
  logic [cnt_w-1:0] nv_q;   // captured tile length
  logic [cnt_w-1:0] iss;    // SRAM reads issued
  logic [cnt_w-1:0] occ;    // vectors resident in L0
  logic [cnt_w-1:0] drn;    // vectors fully drained
  logic [ph_w-1:0]  ph;     // cascade row phase

  logic accept, in_run, fetch_room, vec_pop, last_pop;

  assign accept = (state == st_idle) && start;
  assign in_run = (state == st_run);

  // l0_wr doubles as the in-flight flag: a write issued last cycle has not
  // reached occ yet, so it is counted here to keep its slot reserved.
  assign fetch_room = ({1'b0, occ} + {{cnt_w{1'b0}}, l0_wr}) < depth_lim;

  assign sram_rd = in_run && (iss < nv_q) && fetch_room && l0_ready;
  assign l0_rd   = in_run && (occ != '0) && array_ready;

  // A vector leaves L0 on every broadcast read, but only on the read of the
  // last row in cascade mode.
  assign vec_pop  = l0_rd && (!l0_cascade || (ph == ph_last));
  assign last_pop = vec_pop && ((drn + cnt_one) == nv_q);

  // NOTE: default assignment first, so every path drives state_n and no latch is inferred.
  always_comb begin
    state_n = state;
    case (state)
      st_idle: begin
        if (start) begin
          if (num_vec == '0)     state_n = st_done;
          else if (cascade_mode) state_n = st_align;
          else                   state_n = st_run;
        end
      end
      st_align: state_n = st_run;
      st_run:   if (last_pop) state_n = st_done;
      st_done:  state_n = st_idle;
      default:  state_n = st_idle;
    endcase
  end

  // NOTE: non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= st_idle;
      nv_q       <= '0;
      iss        <= '0;
      occ        <= '0;
      drn        <= '0;
      ph         <= '0;
      sram_addr  <= '0;
      l0_wr      <= 1'b0;
      l0_cascade <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state <= state_n;
      busy  <= (state_n != st_idle);
      done  <= (state_n == st_done);
      l0_wr <= sram_rd;

      if (accept) begin
        nv_q       <= num_vec;
        l0_cascade <= cascade_mode;
        sram_addr  <= base_addr;
        iss        <= '0;
        occ        <= '0;
        drn        <= '0;
        ph         <= '0;
      end else begin
        if (sram_rd) begin
          iss       <= iss + cnt_one;
          sram_addr <= sram_addr + addr_one;  // wraps modulo 2^addr_w
        end

        // A landing write and a completing read in the same cycle cancel.
        if (l0_wr && !vec_pop)      occ <= occ + cnt_one;
        else if (!l0_wr && vec_pop) occ <= occ - cnt_one;

        if (vec_pop) drn <= drn + cnt_one;

        if (l0_rd && l0_cascade) ph <= (ph == ph_last) ? '0 : ph + ph_one;
      end
    end
  end

endmodule

// File: tb/tb_l0_ctrl.sv
// tb_l0_ctrl -- self-checking bench for l0_ctrl.
//
// The reference model tracks a tile as event counts (reads issued, writes
// landed, rows popped, vectors completed) and derives every expected strobe
// from those counts each cycle. Inputs change on the falling edge and outputs
// are sampled 1 ns later.
module tb_l0_ctrl;

  localparam int ROW    = 8;
  localparam int DEPTH  = 64;
  localparam int CNT_W  = 7;
  localparam int ADDR_W = 11;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [CNT_W-1:0]  num_vec;
  logic [ADDR_W-1:0] base_addr;
  logic              cascade_mode;
  logic              array_ready;
  logic              l0_ready;
  logic              sram_rd;
  logic [ADDR_W-1:0] sram_addr;
  logic              l0_wr;
  logic              l0_rd;
  logic              l0_cascade;
  logic              busy;
  logic              done;

  int n_vec = 0;
  int n_err = 0;

  // Per-tile observations filled in by run_tile (cycle numbers, 0 = never).
  int r_srd1, r_wr1, r_rd1, r_done1;
  int r_nsrd, r_nwr, r_nrd, r_ndone, r_srd100;

  always #5 clk = ~clk;

  l0_ctrl #(
    .row    (ROW),
    .depth  (DEPTH),
    .cnt_w  (CNT_W),
    .addr_w (ADDR_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .num_vec      (num_vec),
    .base_addr    (base_addr),
    .cascade_mode (cascade_mode),
    .array_ready  (array_ready),
    .l0_ready     (l0_ready),
    .sram_rd      (sram_rd),
    .sram_addr    (sram_addr),
    .l0_wr        (l0_wr),
    .l0_rd        (l0_rd),
    .l0_cascade   (l0_cascade),
    .busy         (busy),
    .done         (done)
  );

  // Runs one tile from the start pulse (cycle 0) until the cycle after done.
  // rdy_mode: 0 = both ready always, 1 = random readiness,
  //           2 = array stalled through cycle 100, then ready.
  // inject:   pulses start with different operands at cycle 3.
  task automatic run_tile(input int nv, input int base, input bit casc,
                          input int rdy_mode, input bit inject);
    int  iss, wr, pops, vecs, done_cyc, bound, occ_m, first_run;
    bit  pend, fin, ended, run_m, e_srd, e_rd, e_busy, e_done;
    logic [ADDR_W-1:0] e_addr;
    iss = 0; wr = 0; pops = 0; vecs = 0; pend = 0; fin = 0; ended = 0;
    r_srd1 = 0; r_wr1 = 0; r_rd1 = 0; r_done1 = 0;
    r_nsrd = 0; r_nwr = 0; r_nrd = 0; r_ndone = 0; r_srd100 = 0;
    done_cyc  = (nv == 0) ? 1 : 0;
    first_run = casc ? 2 : 1;
    bound     = 200 + nv * ROW * 8;

    @(negedge clk);
    start        = 1'b1;
    num_vec      = CNT_W'(nv);
    base_addr    = ADDR_W'(base);
    cascade_mode = casc;
    array_ready  = 1'b1;
    l0_ready     = 1'b1;

    for (int c = 1; c <= bound; c++) begin
      @(negedge clk);
      start = inject && (c == 3);
      if (inject && c == 3) begin
        num_vec      = CNT_W'($urandom_range(0, DEPTH));
        base_addr    = ADDR_W'($urandom);
        cascade_mode = ~casc;
      end
      case (rdy_mode)
        1: begin
          array_ready = ($urandom % 4) != 0;
          l0_ready    = ($urandom % 5) != 0;
        end
        2: begin
          array_ready = (c > 100);
          l0_ready    = 1'b1;
        end
        default: begin
          array_ready = 1'b1;
          l0_ready    = 1'b1;
        end
      endcase
      #1;

      run_m  = (nv != 0) && (c >= first_run) && !fin;
      occ_m  = wr - vecs;
      e_srd  = run_m && (iss < nv) && (occ_m + int'(pend) < DEPTH) && l0_ready;
      e_rd   = run_m && (occ_m > 0) && array_ready;
      e_busy = (done_cyc == 0) || (c <= done_cyc);
      e_done = (c == done_cyc);
      e_addr = ADDR_W'(base + iss);

      n_vec++;
      if (sram_rd !== e_srd) begin
        n_err++;
        $display("FAIL sram_rd cyc %0d: got %b want %b", c, sram_rd, e_srd);
      end
      n_vec++;
      if (l0_wr !== pend) begin
        n_err++;
        $display("FAIL l0_wr cyc %0d: got %b want %b", c, l0_wr, pend);
      end
      n_vec++;
      if (l0_rd !== e_rd) begin
        n_err++;
        $display("FAIL l0_rd cyc %0d: got %b want %b", c, l0_rd, e_rd);
      end
      n_vec++;
      if (busy !== e_busy) begin
        n_err++;
        $display("FAIL busy cyc %0d: got %b want %b", c, busy, e_busy);
      end
      n_vec++;
      if (done !== e_done) begin
        n_err++;
        $display("FAIL done cyc %0d: got %b want %b", c, done, e_done);
      end
      n_vec++;
      if (l0_cascade !== casc) begin
        n_err++;
        $display("FAIL l0_cascade cyc %0d: got %b want %b", c, l0_cascade, casc);
      end
      if (e_srd) begin
        n_vec++;
        if (sram_addr !== e_addr) begin
          n_err++;
          $display("FAIL sram_addr cyc %0d: got %h want %h", c, sram_addr, e_addr);
        end
      end

      if (sram_rd === 1'b1) begin r_nsrd++;  if (r_srd1 == 0)  r_srd1 = c;  end
      if (l0_wr === 1'b1)   begin r_nwr++;   if (r_wr1 == 0)   r_wr1 = c;   end
      if (l0_rd === 1'b1)   begin r_nrd++;   if (r_rd1 == 0)   r_rd1 = c;   end
      if (done === 1'b1)    begin r_ndone++; if (r_done1 == 0) r_done1 = c; end
      if (c == 100) r_srd100 = r_nsrd;

      if (e_srd) iss++;
      if (pend)  wr++;
      pend = e_srd;
      if (e_rd) begin
        pops++;
        if (!casc || (pops % ROW == 0)) begin
          vecs++;
          if (vecs == nv) begin
            fin      = 1;
            done_cyc = c + 1;
          end
        end
      end

      if (done_cyc != 0 && c > done_cyc) begin
        ended = 1;
        break;
      end
    end

    start = 1'b0;
    n_vec++;
    if (!ended) begin
      n_err++;
      $display("FAIL tile_timeout: no completion within %0d cycles (nv=%0d casc=%0d)",
               bound, nv, casc);
    end
  endtask

  task automatic test_reset();
    reset        = 1'b1;
    start        = 1'b0;
    num_vec      = '0;
    base_addr    = '0;
    cascade_mode = 1'b0;
    array_ready  = 1'b1;
    l0_ready     = 1'b1;
    #2;
    n_vec++;
    if ({sram_rd, l0_wr, l0_rd, l0_cascade, busy, done} !== 6'b0 || sram_addr !== '0) begin
      n_err++;
      $display("FAIL reset_state: got strobes %b addr %h want 000000 addr 000",
               {sram_rd, l0_wr, l0_rd, l0_cascade, busy, done}, sram_addr);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_broadcast();
    run_tile(4, 'h010, 1'b0, 0, 1'b0);
    n_vec++;
    if (r_srd1 !== 1 || r_wr1 !== 2 || r_rd1 !== 3 || r_done1 !== 7) begin
      n_err++;
      $display("FAIL bcast_latency: got srd %0d wr %0d rd %0d done %0d want 1 2 3 7",
               r_srd1, r_wr1, r_rd1, r_done1);
    end
    n_vec++;
    if (r_nsrd !== 4 || r_nwr !== 4 || r_nrd !== 4 || r_ndone !== 1) begin
      n_err++;
      $display("FAIL bcast_counts: got %0d/%0d/%0d/%0d want 4/4/4/1",
               r_nsrd, r_nwr, r_nrd, r_ndone);
    end
  endtask

  task automatic test_cascade();
    run_tile(2, 'h3f0, 1'b1, 0, 1'b0);
    n_vec++;
    if (r_srd1 !== 2 || r_wr1 !== 3 || r_rd1 !== 4) begin
      n_err++;
      $display("FAIL casc_latency: got srd %0d wr %0d rd %0d want 2 3 4",
               r_srd1, r_wr1, r_rd1);
    end
    n_vec++;
    if (r_nrd !== 16 || r_done1 !== r_rd1 + 16 || r_ndone !== 1) begin
      n_err++;
      $display("FAIL casc_drain: got rd %0d done@%0d n_done %0d want 16 reads back to back, one done",
               r_nrd, r_done1, r_ndone);
    end
  endtask

  task automatic test_backpressure();
    run_tile(64, 'h200, 1'b0, 2, 1'b0);
    n_vec++;
    if (r_srd100 !== 64 || r_nsrd !== 64 || r_nwr !== 64) begin
      n_err++;
      $display("FAIL bp_fetch: got srd@100 %0d total srd %0d wr %0d want 64 64 64",
               r_srd100, r_nsrd, r_nwr);
    end
    n_vec++;
    if (r_nrd !== 64 || r_ndone !== 1 || r_done1 <= 100) begin
      n_err++;
      $display("FAIL bp_drain: got rd %0d n_done %0d done@%0d want 64 1 >100",
               r_nrd, r_ndone, r_done1);
    end
  endtask

  task automatic test_zero();
    run_tile(0, 'h123, 1'b0, 1, 1'b0);
    n_vec++;
    if (r_nsrd !== 0 || r_nwr !== 0 || r_nrd !== 0 || r_ndone !== 1) begin
      n_err++;
      $display("FAIL zero_tile: got srd %0d wr %0d rd %0d done %0d want 0 0 0 1",
               r_nsrd, r_nwr, r_nrd, r_ndone);
    end
  endtask

  task automatic test_busy_start();
    run_tile(6, 'h055, 1'b0, 1, 1'b1);
    n_vec++;
    if (r_nsrd !== 6 || r_nrd !== 6 || r_ndone !== 1) begin
      n_err++;
      $display("FAIL busy_start: got srd %0d rd %0d done %0d want 6 6 1",
               r_nsrd, r_nrd, r_ndone);
    end
  endtask

  task automatic test_reset_mid();
    int wr_seen;
    wr_seen = 0;
    @(negedge clk);
    start        = 1'b1;
    num_vec      = CNT_W'(20);
    base_addr    = ADDR_W'('h100);
    cascade_mode = 1'b0;
    array_ready  = 1'b0;
    l0_ready     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 40 && wr_seen < 5; k++) begin
      @(negedge clk);
      #1;
      if (l0_wr === 1'b1) wr_seen++;
    end
    n_vec++;
    if (wr_seen != 5) begin
      n_err++;
      $display("FAIL mid_fetch: got %0d writes want 5", wr_seen);
    end
    // Assert reset between clock edges; outputs must clear without a clock.
    reset       = 1'b1;
    array_ready = 1'b1;
    #1;
    n_vec++;
    if ({sram_rd, l0_wr, l0_rd, l0_cascade, busy, done} !== 6'b0 || sram_addr !== '0) begin
      n_err++;
      $display("FAIL mid_reset: got strobes %b addr %h want 000000 addr 000",
               {sram_rd, l0_wr, l0_rd, l0_cascade, busy, done}, sram_addr);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    #1;
    n_vec++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL post_reset_idle: got busy %b done %b want 0 0", busy, done);
    end
    run_tile(1, int'($urandom_range(0, 2047)), 1'b1, 0, 1'b0);
    n_vec++;
    if (r_nrd !== 8 || r_ndone !== 1) begin
      n_err++;
      $display("FAIL post_reset_tile: got rd %0d done %0d want 8 1", r_nrd, r_ndone);
    end
  endtask

  task automatic test_random();
    int nv, base;
    bit casc;
    for (int t = 0; t < 12; t++) begin
      nv   = (($urandom % 4) == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(1, DEPTH));
      base = (t == 0) ? 2040 : int'($urandom_range(0, 2047));
      casc = (t == 0) ? 1'b0 : 1'($urandom % 2);
      if (t == 0) nv = 20;
      run_tile(nv, base, casc, 1, 1'b0);
      n_vec++;
      if (r_nrd !== nv * (casc ? ROW : 1) || r_nsrd !== nv || r_ndone !== 1) begin
        n_err++;
        $display("FAIL random_tile %0d: got srd %0d rd %0d done %0d want %0d %0d 1 (casc=%0d)",
                 t, r_nsrd, r_nrd, r_ndone, nv, nv * (casc ? ROW : 1), casc);
      end
    end
  endtask

  initial begin
    test_reset();
    test_broadcast();
    test_cascade();
    test_backpressure();
    test_zero();
    test_busy_start();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
